// File: rtl/mux_pkg.sv
// Shared constants and helpers for the round-robin stream multiplexer.
// Provides arbitration mode codes, channel-index width and one-hot decode.
package mux_pkg;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;
    localparam int MAX_CH     = 64;

    function automatic int ch_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // OR-reduction of set indices; exact for a one-hot input.
    function automatic int onehot_to_idx(input logic [MAX_CH-1:0] oh);
        int idx;
        idx = 0;
        for (int i = 0; i < MAX_CH; i++) begin
            if (oh[i]) idx = idx | i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/mux_rr_stream_arbiter.sv
// Combinational one-hot arbiter: fixed priority or round-robin from ptr.
// Ports: req (requests), ptr (rr start), lock_vld/lock_ch (forced grant), grant.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter  int NCH  = 4,
    parameter  int MODE = MODE_RR,
    localparam int CH_W = ch_w(NCH)
) (
    input  logic [NCH-1:0]  req,
    input  logic [CH_W-1:0] ptr,
    input  logic            lock_vld,
    input  logic [CH_W-1:0] lock_ch,
    output logic [NCH-1:0]  grant
);

    logic found;
    int   idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        if (lock_vld) begin
            // Locked channel owns the output even while it is idle.
            for (int i = 0; i < NCH; i++) begin
                if (int'(lock_ch) == i) grant[i] = 1'b1;
            end
        end else if (MODE == MODE_FIXED || NCH == 1) begin
            for (int i = 0; i < NCH; i++) begin
                if (req[i] && !found) begin
                    grant[i] = 1'b1;
                    found    = 1'b1;
                end
            end
        end else begin
            for (int k = 0; k < NCH; k++) begin
                idx = (int'(ptr) + k) % NCH;
                if (req[idx] && !found) begin
                    grant[idx] = 1'b1;
                    found      = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mux_rr_stream.sv
// NCH-to-1 valid/ready stream mux with arbiter, packet lock and output register.
// Ports: in_data/in_valid/in_last/in_ready per channel; out_data/out_ch/out_last/out_valid/out_ready.
module mux_rr_stream
    import mux_pkg::*;
#(
    parameter  int WIDTH    = 32,
    parameter  int NCH      = 4,
    parameter  int MODE     = MODE_RR,
    parameter  int PKT_LOCK = 0,
    localparam int CH_W     = ch_w(NCH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    input  logic [NCH-1:0]       in_last,
    output logic [NCH-1:0]       in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [CH_W-1:0]      out_ch,
    output logic                 out_last,
    output logic                 out_valid,
    input  logic                 out_ready
);

    logic             load_en;
    logic [NCH-1:0]   grant;
    logic [NCH-1:0]   xfer_vec;
    logic             xfer;
    logic             xfer_last;
    logic [CH_W-1:0]  xfer_ch;
    logic [WIDTH-1:0] xfer_data;
    logic [CH_W-1:0]  rr_ptr;
    logic [CH_W-1:0]  ptr_nxt;
    logic             lock_vld;
    logic [CH_W-1:0]  lock_ch;

    rr_arbiter #(
        .NCH  (NCH),
        .MODE (MODE)
    ) u_arb (
        .req      (in_valid),
        .ptr      (rr_ptr),
        .lock_vld (lock_vld),
        .lock_ch  (lock_ch),
        .grant    (grant)
    );

    assign load_en   = !out_valid || out_ready;
    assign in_ready  = rst_n ? (grant & {NCH{load_en}}) : '0;
    assign xfer_vec  = in_valid & in_ready;
    assign xfer      = |xfer_vec;
    assign xfer_last = |(xfer_vec & in_last);
    assign xfer_ch   = CH_W'(onehot_to_idx(MAX_CH'(xfer_vec)));

    always_comb begin
        xfer_data = '0;
        for (int i = 0; i < NCH; i++) begin
            if (xfer_vec[i]) xfer_data = xfer_data | in_data[i*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        ptr_nxt = '0;
        if (NCH > 1 && int'(xfer_ch) != NCH - 1) begin
            ptr_nxt = xfer_ch + CH_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            out_last  <= 1'b0;
            rr_ptr    <= '0;
            lock_vld  <= 1'b0;
            lock_ch   <= '0;
        end else begin
            if (xfer) begin
                out_valid <= 1'b1;
                out_data  <= xfer_data;
                out_ch    <= xfer_ch;
                out_last  <= xfer_last;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            // Inside a packet the pointer advances only on its last beat.
            if (xfer && (!lock_vld || xfer_last)) begin
                rr_ptr <= ptr_nxt;
            end
            if (PKT_LOCK != 0 && xfer) begin
                if (!lock_vld && !xfer_last) begin
                    lock_vld <= 1'b1;
                    lock_ch  <= xfer_ch;
                end else if (lock_vld && xfer_last) begin
                    lock_vld <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mux_rr_stream.sv
// Bench for mux_rr_stream: round-robin/locking and fixed-priority instances.
// Both share inputs; the round-robin output is checked against a beat queue.
module tb_mux_rr_stream;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] in_data;
    logic [3:0]   in_valid;
    logic [3:0]   in_last;
    logic         out_ready;

    logic [3:0]   rr_in_ready;
    logic [31:0]  rr_out_data;
    logic [1:0]   rr_out_ch;
    logic         rr_out_last;
    logic         rr_out_valid;

    logic [3:0]   fp_in_ready;
    logic [31:0]  fp_out_data;
    logic [1:0]   fp_out_ch;
    logic         fp_out_last;
    logic         fp_out_valid;

    always #5 clk = ~clk;

    mux_rr_stream #(
        .WIDTH    (32),
        .NCH      (4),
        .MODE     (1),
        .PKT_LOCK (1)
    ) u_rr (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (rr_in_ready),
        .out_data  (rr_out_data),
        .out_ch    (rr_out_ch),
        .out_last  (rr_out_last),
        .out_valid (rr_out_valid),
        .out_ready (out_ready)
    );

    mux_rr_stream #(
        .WIDTH    (32),
        .NCH      (4),
        .MODE     (0),
        .PKT_LOCK (0)
    ) u_fp (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (fp_in_ready),
        .out_data  (fp_out_data),
        .out_ch    (fp_out_ch),
        .out_last  (fp_out_last),
        .out_valid (fp_out_valid),
        .out_ready (out_ready)
    );

    typedef struct packed {
        logic [3:0] v;
        logic [3:0] er;
        logic [3:0] ef;
    } vec_t;

    typedef struct packed {
        logic [1:0]  ch;
        logic [31:0] data;
        logic        last;
    } beat_t;

    beat_t       q[$];
    vec_t        tbl[10];
    logic [31:0] chd[4];
    int          n_run;
    int          n_fail;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_data();
        for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = chd[i];
    endtask

    function automatic int oh_idx(input logic [3:0] oh);
        int r;
        r = 0;
        for (int i = 0; i < 4; i++) if (oh[i]) r = i;
        return r;
    endfunction

    // One cycle: drive, check readies, pop any output beat, push expected beat.
    task automatic row(input logic [3:0] v, input logic [3:0] l,
                       input logic o, input logic [3:0] er,
                       input logic [3:0] ef, input bit cf);
        beat_t b;
        beat_t e;
        int    c;
        in_valid  = v;
        in_last   = l;
        out_ready = o;
        #1;
        chk("rr_in_ready", 32'(rr_in_ready), 32'(er));
        if (cf) chk("fp_in_ready", 32'(fp_in_ready), 32'(ef));
        if (rst_n && rr_out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_beat", 32'(rr_out_ch), 32'hFFFF_FFFF);
            end else begin
                e = q.pop_front();
                chk("out_ch", 32'(rr_out_ch), 32'(e.ch));
                chk("out_data", rr_out_data, e.data);
                chk("out_last", 32'(rr_out_last), 32'(e.last));
            end
        end
        if (rst_n && (v & er) != 4'b0) begin
            c      = oh_idx(v & er);
            b.ch   = 2'(c);
            b.data = chd[c];
            b.last = l[c];
            q.push_back(b);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_run  = 0;
        n_fail = 0;
        for (int i = 0; i < 4; i++) chd[i] = 32'h0000_00A0 + 32'(i);
        set_data();
        rst_n     = 1'b0;
        in_valid  = 4'b1111;
        in_last   = 4'b1111;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rr_in_ready", 32'(rr_in_ready), 32'h0);
        chk("rst_fp_in_ready", 32'(fp_in_ready), 32'h0);
        chk("rst_out_valid", 32'(rr_out_valid), 32'h0);
        chk("rst_out_data", rr_out_data, 32'h0);
        chk("rst_out_ch", 32'(rr_out_ch), 32'h0);
        rst_n = 1'b1;

        tbl[0] = '{v: 4'b1111, er: 4'b0001, ef: 4'b0001};
        tbl[1] = '{v: 4'b1111, er: 4'b0010, ef: 4'b0001};
        tbl[2] = '{v: 4'b1111, er: 4'b0100, ef: 4'b0001};
        tbl[3] = '{v: 4'b1111, er: 4'b1000, ef: 4'b0001};
        tbl[4] = '{v: 4'b1111, er: 4'b0001, ef: 4'b0001};
        tbl[5] = '{v: 4'b1010, er: 4'b0010, ef: 4'b0010};
        tbl[6] = '{v: 4'b1010, er: 4'b1000, ef: 4'b0010};
        tbl[7] = '{v: 4'b1010, er: 4'b0010, ef: 4'b0010};
        tbl[8] = '{v: 4'b1000, er: 4'b1000, ef: 4'b1000};
        tbl[9] = '{v: 4'b0000, er: 4'b0000, ef: 4'b0000};
        for (int i = 0; i < 10; i++) begin
            row(tbl[i].v, 4'b1111, 1'b1, tbl[i].er, tbl[i].ef, 1'b1);
        end
        row(4'b0000, 4'b1111, 1'b1, 4'b0000, 4'b0000, 1'b1);

        // Backpressure: hold a beat for three cycles, then pop and push together.
        chd[0] = 32'h0000_1000;
        set_data();
        row(4'b0001, 4'b1111, 1'b1, 4'b0001, 4'b0001, 1'b1);
        for (int i = 0; i < 3; i++) begin
            row(4'b0011, 4'b1111, 1'b0, 4'b0000, 4'b0000, 1'b1);
            chk("hold_data", rr_out_data, 32'h0000_1000);
            chk("hold_ch", 32'(rr_out_ch), 32'h0);
            chk("hold_valid", 32'(rr_out_valid), 32'h1);
        end
        row(4'b0011, 4'b1111, 1'b1, 4'b0010, 4'b0001, 1'b1);
        row(4'b0000, 4'b1111, 1'b1, 4'b0000, 4'b0000, 1'b1);
        chd[0] = 32'h0000_00A0;
        set_data();

        // Packet lock on ch2 with ch0 waiting, then wrap back to ch0.
        row(4'b0101, 4'b0000, 1'b1, 4'b0100, 4'b0000, 1'b0);
        row(4'b0101, 4'b0000, 1'b1, 4'b0100, 4'b0000, 1'b0);
        row(4'b0101, 4'b0100, 1'b1, 4'b0100, 4'b0000, 1'b0);
        row(4'b0001, 4'b0001, 1'b1, 4'b0001, 4'b0000, 1'b0);
        // Lock ch1, then let it idle: no grant elsewhere, output drains.
        row(4'b0010, 4'b0000, 1'b1, 4'b0010, 4'b0000, 1'b0);
        row(4'b0100, 4'b0000, 1'b1, 4'b0010, 4'b0000, 1'b0);
        chk("idle_lock_valid", 32'(rr_out_valid), 32'h0);
        row(4'b0110, 4'b0000, 1'b1, 4'b0010, 4'b0000, 1'b0);
        chk("lock_beat_valid", 32'(rr_out_valid), 32'h1);

        // Reset mid-packet with a beat held in the output register.
        rst_n = 1'b0;
        row(4'b0110, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b1);
        chk("mid_rst_valid", 32'(rr_out_valid), 32'h0);
        chk("mid_rst_data", rr_out_data, 32'h0);
        chk("mid_rst_last", 32'(rr_out_last), 32'h0);
        if (q.size() > 0) void'(q.pop_front());
        rst_n = 1'b1;
        row(4'b1001, 4'b1111, 1'b1, 4'b0001, 4'b0001, 1'b1);
        row(4'b0000, 4'b1111, 1'b1, 4'b0000, 4'b0000, 1'b1);
        row(4'b0000, 4'b1111, 1'b1, 4'b0000, 4'b0000, 1'b1);
        chk("queue_empty", 32'(q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
